// File: rtl/colour_scheduler.sv
// Horizontal line sequencer: SYNC/BACK/ACTIVE/FRONT timing, 4-entry pixel FIFO, underrun flag.
// Optional `COLOUR_SCHED_STATS_EN adds a saturating underrun_count output.
module colour_scheduler #(
  parameter int          CLKS_PER_PIXEL = 4,
  parameter int          SYNC_PIX       = 4,
  parameter int          BACK_PIX       = 6,
  parameter int          ACTIVE_PIX     = 40,
  parameter int          FRONT_PIX      = 2,
  parameter logic [5:0]  BLANK_COLOUR   = 6'h00,
  parameter logic [5:0]  BORDER_COLOUR  = 6'h3F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [5:0] colourNum,
  output logic       sync,
  output logic       blank,
  output logic       line_start,
  output logic       underrun
`ifdef COLOUR_SCHED_STATS_EN
  ,
  output logic [15:0] underrun_count
`endif
);

  localparam int MAX_SB  = (SYNC_PIX > BACK_PIX) ? SYNC_PIX : BACK_PIX;
  localparam int MAX_AF  = (ACTIVE_PIX > FRONT_PIX) ? ACTIVE_PIX : FRONT_PIX;
  localparam int MAX_PIX = (MAX_SB > MAX_AF) ? MAX_SB : MAX_AF;
  localparam int CW      = $clog2(CLKS_PER_PIXEL);
  localparam int PW      = (MAX_PIX > 1) ? $clog2(MAX_PIX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_BACK,
    S_ACTIVE,
    S_FRONT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
  logic [PW-1:0]   pix_cnt_q, pix_cnt_d;
  logic [PW-1:0]   last_pix;
  logic            slot_end, state_end, slot_start;
  logic            line_start_d;
  logic [5:0]      colour_d;

  logic [5:0]      mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      count;
  logic            push, pop, underrun_hit;

  assign pix_ready    = (count != 3'd4);
  assign push         = pix_valid && pix_ready;
  assign pop          = slot_start && (count != 3'd0);
  assign underrun_hit = slot_start && (count == 3'd0);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = '0;
    pix_cnt_d    = '0;
    line_start_d = 1'b0;
    slot_start   = 1'b0;
    last_pix     = '0;

    case (state_q)
      S_SYNC:   last_pix = PW'(SYNC_PIX - 1);
      S_BACK:   last_pix = PW'(BACK_PIX - 1);
      S_ACTIVE: last_pix = PW'(ACTIVE_PIX - 1);
      S_FRONT:  last_pix = PW'(FRONT_PIX - 1);
      default:  last_pix = '0;
    endcase

    slot_end  = (clk_cnt_q == CW'(CLKS_PER_PIXEL - 1));
    state_end = slot_end && (pix_cnt_q == last_pix);

    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d      = S_SYNC;
        line_start_d = 1'b1;
      end
    end else begin
      clk_cnt_d = slot_end ? '0 : clk_cnt_q + CW'(1);
      if (state_end)     pix_cnt_d = '0;
      else if (slot_end) pix_cnt_d = pix_cnt_q + PW'(1);
      else               pix_cnt_d = pix_cnt_q;

      if (state_end) begin
        case (state_q)
          S_SYNC:   state_d = S_BACK;
          S_BACK: begin
            state_d    = S_ACTIVE;
            slot_start = 1'b1;
          end
          S_ACTIVE: state_d = S_FRONT;
          S_FRONT: begin
            // enable is only honoured here, so a started line always completes
            if (enable) begin
              state_d      = S_SYNC;
              line_start_d = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
          default:  state_d = S_IDLE;
        endcase
      end else if (state_q == S_ACTIVE && slot_end) begin
        slot_start = 1'b1;
      end
    end

    if (slot_start)              colour_d = (count != 3'd0) ? mem[rd_ptr] : BORDER_COLOUR;
    else if (state_d == S_ACTIVE) colour_d = colourNum;
    else                          colour_d = BLANK_COLOUR;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      colourNum  <= BLANK_COLOUR;
      sync       <= 1'b0;
      blank      <= 1'b1;
      line_start <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      colourNum  <= colour_d;
      sync       <= (state_d == S_SYNC);
      blank      <= (state_d != S_ACTIVE);
      line_start <= line_start_d;
      if (underrun_hit) underrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by count, so stale words are never read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pix_data;
  end

`ifdef COLOUR_SCHED_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      underrun_count <= '0;
    end else if (underrun_hit && underrun_count != 16'hFFFF) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_colour_scheduler.sv
// Self-checking bench for colour_scheduler: line-position reference model feeds a scoreboard
// queue; a negedge monitor pops and compares every cycle.
module tb_colour_scheduler;

  localparam int CPP    = 4;
  localparam int A0     = (4 + 6) * CPP;
  localparam int A1     = A0 + 40 * CPP;
  localparam int SYNC_E = 4 * CPP;
  localparam int LINE   = (4 + 6 + 40 + 2) * CPP;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [5:0] colourNum;
  logic       sync, blank, line_start, underrun;
`ifdef COLOUR_SCHED_STATS_EN
  logic [15:0] underrun_count;
`endif

  colour_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .colourNum  (colourNum),
    .sync       (sync),
    .blank      (blank),
    .line_start (line_start),
    .underrun   (underrun)
`ifdef COLOUR_SCHED_STATS_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        sync;
    logic        blank;
    logic        ls;
    logic        ur;
    logic [5:0]  col;
    logic [15:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] m_q[$];
  int         m_pos;
  logic       m_ur;
  logic [5:0] m_col;
  logic [15:0] m_cnt;

  int checks = 0;
  int fails  = 0;
  int ls_count = 0;
  int seq = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.rdy   = (m_q.size() != 4);
    e.sync  = (m_pos >= 0 && m_pos < SYNC_E);
    e.blank = !(m_pos >= A0 && m_pos < A1);
    e.ls    = (m_pos == 0);
    e.ur    = m_ur;
    e.col   = m_col;
    e.cnt   = m_cnt;
    exp_q.push_back(e);
  endtask

  // Reference model: position within the line in clocks, -1 when idle.
  initial begin
    m_pos = -1; m_ur = 1'b0; m_col = 6'h00; m_cnt = 16'd0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pos = -1;
        m_q.delete();
        m_ur  = 1'b0;
        m_col = 6'h00;
        m_cnt = 16'd0;
        exp_q.delete();
        push_exp();
      end else begin
        automatic bit ready_b = (m_q.size() < 4);
        if (m_pos < 0)              m_pos = enable ? 0 : -1;
        else if (m_pos == LINE - 1) m_pos = enable ? 0 : -1;
        else                        m_pos++;
        if (m_pos >= A0 && m_pos < A1) begin
          if ((m_pos - A0) % CPP == 0) begin
            if (m_q.size() > 0) m_col = m_q.pop_front();
            else begin
              m_col = 6'h3F;
              m_ur  = 1'b1;
              if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
          end
        end else begin
          m_col = 6'h00;
        end
        if (pix_valid && ready_b) m_q.push_back(pix_data);
        push_exp();
      end
    end
  end

  // Monitor: one expected entry per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pix_ready",  16'(pix_ready),  16'(e.rdy));
      check("sync",       16'(sync),       16'(e.sync));
      check("blank",      16'(blank),      16'(e.blank));
      check("line_start", 16'(line_start), 16'(e.ls));
      check("underrun",   16'(underrun),   16'(e.ur));
      check("colourNum",  16'(colourNum),  16'(e.col));
`ifdef COLOUR_SCHED_STATS_EN
      check("underrun_count", underrun_count, e.cnt);
`endif
    end
    if (line_start === 1'b1) ls_count++;
  end

  // mode 0: idle, 1: continuous sequence i mod 64, 2: sparse random words
  task automatic run(input int cycles, input int mode);
    for (int i = 0; i < cycles; i++) begin
      automatic bit hs;
      @(negedge clk);
      hs = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (hs) seq++;
      case (mode)
        1: begin
          pix_valid = 1'b1;
          pix_data  = 6'(seq);
        end
        2: begin
          if (hs || !pix_valid) pix_data = 6'($urandom);
          pix_valid = ($urandom_range(0, 5) == 0);
        end
        default: pix_valid = 1'b0;
      endcase
    end
  endtask

  task automatic wait_active(input int mode, input int min_pos, input int qsz);
    bit found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (m_pos >= min_pos && m_pos < A1 && (qsz < 0 || m_q.size() == qsz)) begin
        found = 1'b1;
        break;
      end
      run(1, mode);
    end
    if (!found) begin
      checks++;
      fails++;
      $display("FAIL wait_active timeout at %0t: pos %0d fifo %0d", $time, m_pos, m_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    int ls_before;
    reset = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_data = 6'h00;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    enable = 1'b1;
    #2 reset = 1'b1;

    // Empty FIFO: every active slot underruns.
    run(2 * LINE + 10, 0);

    // Pre-fill 0..3 while idle, then stream i mod 64.
    enable = 1'b0;
    do_reset();
    seq = 0;
    run(8, 1);
    enable = 1'b1;
    run(2 * LINE + 20, 1);

    // Random feed with occasional enable changes.
    for (int k = 0; k < 10; k++) begin
      run(150, 2);
      enable = ($urandom_range(0, 3) != 0);
    end

    // Drop enable mid-ACTIVE: line completes, no further line starts.
    enable = 1'b1;
    wait_active(1, A0 + 20, -1);
    enable = 1'b0;
    run(LINE - A0 - 10, 1);
    ls_before = ls_count;
    run(2 * LINE, 1);
    check("no_line_start_after_disable", 16'(ls_count - ls_before), 16'd0);

    // Reset mid-ACTIVE with two entries queued.
    enable = 1'b1;
    wait_active(0, A0, 2);
    do_reset();
    run(10, 0);
    run(LINE + 20, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
